sps_cmd_arbiter: RTL and testbench

SPS_CMD_ARBITER -- requirements
Module: sps_cmd_arbiter

---
 rtl/sps_cmd_arbiter_if.sv | 29 ++
 rtl/sps_cmd_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sps_cmd_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sps_cmd_arbiter_if.sv
// Requester-side bus of the SPS command arbiter.
//   req_i    : per-requester level request (bit n = requester n)
//   cmd0_i/1 : {rws[2:0], burst_en, burst_len[3:0], addr[19:0], wdata[15:0]}
//   gnt_o    : one-cycle grant pulse, command of that requester latched
//   done_o   : one-cycle completion pulse for the granted requester
//   rdata_o  : read data, valid with done_o and held until the next read done
//   err_o    : pulses with done_o when the command was rejected (rws = 000)
//   busy_o   : arbiter is not idle
// master: requester side, slave: arbiter side.
interface sps_cmd_arbiter_if;
  logic [1:0]  req_i;
  logic [43:0] cmd0_i;
  logic [43:0] cmd1_i;
  logic [1:0]  gnt_o;
  logic [1:0]  done_o;
  logic [15:0] rdata_o;
  logic        err_o;
  logic        busy_o;

  modport master (
    output req_i, cmd0_i, cmd1_i,
    input  gnt_o, done_o, rdata_o, err_o, busy_o
  );

  modport slave (
    input  req_i, cmd0_i, cmd1_i,
    output gnt_o, done_o, rdata_o, err_o, busy_o
  );
endinterface

// File: rtl/sps_cmd_arbiter.sv
// Two-requester round-robin command arbiter driving a serial SPS shifter
// and collecting 16-bit read data from a serial PTS return line.
//   FPGA_clk / FPGA_rst_n : sole clock (rising edge), async active-low reset
//   bus                   : requester bus (slave modport)
//   SPS_clk_out           : shifter clock, HALF_DIV cycles low then high
//   SPS_rst_out           : shifter reset, high in IDLE and DONE
//   burst_en_out, mode_sel_out : latched burst_en for the transaction
//   burst_len_out, addr_out, data_out : serial lanes, LSB first, 20 periods
//   rws_out               : latched rws for the transaction
//   PTS_ser_data_in       : serial read data, LSB first, 16 periods
// Write: gnt..done spans 40*HALF_DIV+2 cycles; read: 72*HALF_DIV+2.
module sps_cmd_arbiter #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic                   FPGA_clk,
  input  logic                   FPGA_rst_n,
  sps_cmd_arbiter_if.slave       bus,
  output logic                   SPS_clk_out,
  output logic                   SPS_rst_out,
  output logic                   burst_en_out,
  output logic                   mode_sel_out,
  output logic                   burst_len_out,
  output logic                   addr_out,
  output logic                   data_out,
  output logic [2:0]             rws_out,
  input  logic                   PTS_ser_data_in
);

  // Phase counter spans 0..2*HALF_DIV-1 (up to 29); period counter runs
  // continuously 0..35 across SHIFT (0..19) and READ (20..35).
  localparam logic [4:0] PH_HI      = 5'(HALF_DIV);
  localparam logic [4:0] PH_LAST    = 5'(2 * HALF_DIV - 1);
  localparam logic [5:0] SHIFT_LAST = 6'd19;
  localparam logic [5:0] READ_LAST  = 6'd35;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, READ, DONE} state_e;

  state_e      state_q, state_d;
  logic [43:0] cmd_q, cmd_d;
  logic        own_q, own_d;
  logic        last_q, last_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [4:0]  ph_q, ph_d;
  logic [5:0]  per_q, per_d;
  logic [15:0] rsh_q, rsh_d;
  logic [15:0] rdata_q, rdata_d;
  logic        winner;

  logic [2:0]  cmd_rws;
  logic        cmd_burst_en;
  logic [3:0]  cmd_blen;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;

  assign cmd_rws      = cmd_q[43:41];
  assign cmd_burst_en = cmd_q[40];
  assign cmd_blen     = cmd_q[39:36];
  assign cmd_addr     = cmd_q[35:16];
  assign cmd_wdata    = cmd_q[15:0];

  always_ff @(posedge FPGA_clk or negedge FPGA_rst_n) begin
    if (!FPGA_rst_n) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      ph_q    <= '0;
      per_q   <= '0;
      rsh_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      own_q   <= own_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      ph_q    <= ph_d;
      per_q   <= per_d;
      rsh_q   <= rsh_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    own_d   = own_q;
    last_d  = last_q;
    gnt_d   = '0;
    ph_d    = ph_q;
    per_d   = per_q;
    rsh_d   = rsh_q;
    rdata_d = rdata_q;
    winner  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|bus.req_i) begin
          // Both requesting: the one not granted last wins.
          winner  = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
          own_d   = winner;
          cmd_d   = winner ? bus.cmd1_i : bus.cmd0_i;
          gnt_d   = winner ? 2'b10 : 2'b01;
          ph_d    = '0;
          per_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = (cmd_rws == 3'b000) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d  = '0;
          per_d = per_q + 6'd1;
          if (per_q == SHIFT_LAST) begin
            state_d = cmd_rws[0] ? DONE : READ;
          end
        end else begin
          ph_d = ph_q + 5'd1;
        end
      end
      READ: begin
        // Sample in the first high cycle of each SPS_clk period.
        if (ph_q == PH_HI) begin
          for (int unsigned k = 0; k < 16; k++) begin
            if (per_q == 6'(k + 20)) rsh_d[k] = PTS_ser_data_in;
          end
        end
        if (ph_q == PH_LAST) begin
          ph_d  = '0;
          per_d = per_q + 6'd1;
          if (per_q == READ_LAST) begin
            // rsh_d already holds the final sample when HALF_DIV = 1.
            rdata_d = rsh_d;
            state_d = DONE;
          end
        end else begin
          ph_d = ph_q + 5'd1;
        end
      end
      DONE: begin
        last_d  = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SPS_clk_out   = ((state_q == SHIFT) || (state_q == READ)) && (ph_q >= PH_HI);
    SPS_rst_out   = (state_q == IDLE) || (state_q == DONE);
    burst_en_out  = (state_q != IDLE) && cmd_burst_en;
    mode_sel_out  = (state_q != IDLE) && cmd_burst_en;
    rws_out       = (state_q != IDLE) ? cmd_rws : 3'b000;
    addr_out      = 1'b0;
    data_out      = 1'b0;
    burst_len_out = 1'b0;
    if (state_q == SHIFT) begin
      addr_out      = cmd_addr[per_q[4:0]];
      data_out      = (per_q < 6'd16) ? cmd_wdata[per_q[3:0]] : 1'b0;
      burst_len_out = (per_q < 6'd4) ? cmd_blen[per_q[1:0]] : 1'b0;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = (state_q == DONE) ? (own_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.err_o   = (state_q == DONE) && (cmd_rws == 3'b000);
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_sps_cmd_arbiter.sv
module tb_sps_cmd_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sps_cmd_arbiter_if bus ();
  sps_cmd_arbiter_if bus1 ();

  logic sclk, srst, be, ms, bl, ad, dt, pts;
  logic [2:0] rws;
  logic sclk1, srst1, be1, ms1, bl1, ad1, dt1, pts1;
  logic [2:0] rws1;

  sps_cmd_arbiter #(.HALF_DIV(2)) dut (
    .FPGA_clk(clk), .FPGA_rst_n(rst_n), .bus(bus),
    .SPS_clk_out(sclk), .SPS_rst_out(srst), .burst_en_out(be),
    .mode_sel_out(ms), .burst_len_out(bl), .addr_out(ad), .data_out(dt),
    .rws_out(rws), .PTS_ser_data_in(pts)
  );

  sps_cmd_arbiter #(.HALF_DIV(1)) dut1 (
    .FPGA_clk(clk), .FPGA_rst_n(rst_n), .bus(bus1),
    .SPS_clk_out(sclk1), .SPS_rst_out(srst1), .burst_en_out(be1),
    .mode_sel_out(ms1), .burst_len_out(bl1), .addr_out(ad1), .data_out(dt1),
    .rws_out(rws1), .PTS_ser_data_in(pts1)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [43:0] mk(input logic [2:0] r, input logic b, input logic [3:0] l,
                                     input logic [19:0] a, input logic [15:0] w);
    return {r, b, l, a, w};
  endfunction

  typedef struct {
    logic [1:0]  req;
    logic [43:0] cmd0;
    logic [43:0] cmd1;
    logic [15:0] pts;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic        err;
    logic [15:0] rdata;
    int          cycles;
    int          rises;
  } vec_t;

  vec_t vt[6];

  task automatic run_vec(input int idx, input vec_t v);
    int w, cyc, rises, nz;
    logic prev;
    logic [43:0] cmd;
    logic [19:0] a_cap, d_cap, l_cap;
    a_cap = '0; d_cap = '0; l_cap = '0; nz = 0;
    @(negedge clk);
    bus.req_i = v.req; bus.cmd0_i = v.cmd0; bus.cmd1_i = v.cmd1;
    w = 0;
    do begin @(negedge clk); w++; end while (bus.gnt_o == 2'b00 && w < 10);
    bus.req_i = 2'b00;
    cmd = (v.gnt == 2'b10) ? v.cmd1 : v.cmd0;
    chk($sformatf("v%0d gnt", idx), bus.gnt_o, v.gnt);
    chk($sformatf("v%0d rws_out", idx), rws, cmd[43:41]);
    chk($sformatf("v%0d burst_en", idx), be, cmd[40]);
    chk($sformatf("v%0d mode_sel", idx), ms, cmd[40]);
    chk($sformatf("v%0d busy", idx), bus.busy_o, 1'b1);
    chk($sformatf("v%0d load_rst", idx), srst, 1'b0);
    cyc = 1; rises = 0; prev = sclk;
    while (bus.done_o == 2'b00 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sclk && !prev) begin
        rises++;
        if (rises <= 20) begin
          a_cap[rises-1] = ad; d_cap[rises-1] = dt; l_cap[rises-1] = bl;
        end else if (rises <= 36) begin
          pts = v.pts[rises-21];
        end
      end
      if (rises > 20 && (ad || dt || bl)) nz++;
      prev = sclk;
    end
    chk($sformatf("v%0d done", idx), bus.done_o, v.done);
    chk($sformatf("v%0d err", idx), bus.err_o, v.err);
    chk($sformatf("v%0d rdata", idx), bus.rdata_o, v.rdata);
    chk($sformatf("v%0d cycles", idx), cyc, v.cycles);
    chk($sformatf("v%0d rises", idx), rises, v.rises);
    chk($sformatf("v%0d done_rst", idx), srst, 1'b1);
    if (cmd[43:41] != 3'b000) begin
      chk($sformatf("v%0d addr_lane", idx), a_cap, cmd[35:16]);
      chk($sformatf("v%0d data_lane", idx), d_cap, {4'h0, cmd[15:0]});
      chk($sformatf("v%0d blen_lane", idx), l_cap, {16'h0, cmd[39:36]});
      if (!cmd[41]) chk($sformatf("v%0d read_lanes", idx), nz, 0);
    end
    @(negedge clk);
    chk($sformatf("v%0d idle", idx), bus.busy_o, 1'b0);
    pts = 1'b0;
  endtask

  initial begin
    int w, c, ng, nd, ovl, tog;
    logic out;
    logic prev;
    logic [1:0] gseq[3];
    logic [1:0] dseq[3];
    logic [19:0] a1;

    bus.req_i = '0; bus.cmd0_i = '0; bus.cmd1_i = '0; pts = 1'b0;
    bus1.req_i = '0; bus1.cmd0_i = '0; bus1.cmd1_i = '0; pts1 = 1'b0;

    //                req    cmd0                               cmd1                              pts      gnt    done   err  rdata    cyc  rises
    vt[0] = '{2'b01, mk(3'b001,1,4'h5,20'hABCDE,16'h1234), 44'h0,                              16'h0,   2'b01, 2'b01, 0, 16'h0000, 82,  20};
    vt[1] = '{2'b10, 44'h0,                              mk(3'b010,0,4'h0,20'h12345,16'h0000), 16'hBEEF, 2'b10, 2'b10, 0, 16'hBEEF, 146, 36};
    vt[2] = '{2'b01, mk(3'b100,1,4'hA,20'h00001,16'hFFFF), 44'h0,                              16'h5A5A, 2'b01, 2'b01, 0, 16'h5A5A, 146, 36};
    vt[3] = '{2'b10, 44'h0,                              mk(3'b011,0,4'hF,20'hFFFFF,16'hFFFF), 16'h0,   2'b10, 2'b10, 0, 16'h5A5A, 82,  20};
    vt[4] = '{2'b11, mk(3'b111,1,4'h3,20'h80001,16'h8001), mk(3'b001,0,4'h1,20'h11111,16'h1111), 16'h0, 2'b01, 2'b01, 0, 16'h5A5A, 82,  20};
    vt[5] = '{2'b11, mk(3'b001,0,4'h1,20'h22222,16'h2222), mk(3'b000,1,4'h2,20'h33333,16'h3333), 16'h0, 2'b10, 2'b10, 1, 16'h5A5A, 2,   0};

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst busy", bus.busy_o, 1'b0);
    chk("rst gnt", bus.gnt_o, 2'b00);
    chk("rst done", bus.done_o, 2'b00);
    chk("rst err", bus.err_o, 1'b0);
    chk("rst rdata", bus.rdata_o, 16'h0);
    chk("rst sps_rst", srst, 1'b1);
    chk("rst sps_clk", sclk, 1'b0);
    chk("rst lanes", {be, ms, bl, ad, dt, rws}, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

    // Both held: grants alternate 01,10,01 (last grant was requester 1)
    @(negedge clk);
    bus.cmd0_i = mk(3'b000, 0, 4'h0, 20'h0, 16'h0);
    bus.cmd1_i = mk(3'b001, 0, 4'h0, 20'h00055, 16'h0055);
    bus.req_i = 2'b11;
    c = 0; ng = 0; nd = 0; ovl = 0; out = 1'b0;
    while (nd < 3 && c < 400) begin
      @(negedge clk);
      c++;
      if (bus.gnt_o != 2'b00) begin
        if (out) ovl++;
        if (ng < 3) gseq[ng] = bus.gnt_o;
        ng++; out = 1'b1;
        if (ng >= 3) bus.req_i = 2'b00;
      end
      if (bus.done_o != 2'b00) begin
        if (nd < 3) dseq[nd] = bus.done_o;
        nd++; out = 1'b0;
      end
    end
    chk("rr grant count", ng, 3);
    chk("rr gnt0", gseq[0], 2'b01);
    chk("rr gnt1", gseq[1], 2'b10);
    chk("rr gnt2", gseq[2], 2'b01);
    chk("rr done seq", {dseq[0], dseq[1], dseq[2]}, 6'b01_10_01);
    chk("rr no gnt while busy", ovl, 0);

    // Reset during SHIFT period 7
    @(negedge clk);
    bus.cmd0_i = mk(3'b001, 1, 4'h9, 20'hABCDE, 16'h1234);
    bus.req_i = 2'b01;
    w = 0;
    do begin @(negedge clk); w++; end while (bus.gnt_o == 2'b00 && w < 10);
    bus.req_i = 2'b00;
    chk("mid gnt", bus.gnt_o, 2'b01);
    c = 0; ng = 0; prev = sclk;
    while (ng < 8 && c < 200) begin
      @(negedge clk); c++;
      if (sclk && !prev) ng++;
      prev = sclk;
    end
    chk("mid reached period 7", ng, 8);
    rst_n = 1'b0;
    #1;
    chk("mid rst busy", bus.busy_o, 1'b0);
    chk("mid rst sps_rst", srst, 1'b1);
    chk("mid rst sps_clk", sclk, 1'b0);
    chk("mid rst lanes", {be, ms, bl, ad, dt, rws}, 8'h00);
    chk("mid rst rdata", bus.rdata_o, 16'h0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done_o != 2'b00) nd++;
    end
    chk("mid no done", nd, 0);
    rst_n = 1'b1;
    bus.cmd0_i = mk(3'b000, 0, 4'h0, 20'h0, 16'h0);
    bus.cmd1_i = mk(3'b000, 0, 4'h0, 20'h0, 16'h0);
    bus.req_i = 2'b11;
    w = 0;
    do begin @(negedge clk); w++; end while (bus.gnt_o == 2'b00 && w < 10);
    bus.req_i = 2'b00;
    chk("post rst gnt", bus.gnt_o, 2'b01);
    w = 0;
    do begin @(negedge clk); w++; end while (bus.done_o == 2'b00 && w < 10);
    chk("post rst done", bus.done_o, 2'b01);

    // HALF_DIV = 1 write
    @(negedge clk);
    bus1.cmd0_i = mk(3'b001, 1, 4'h3, 20'h0F0F0, 16'hA5A5);
    bus1.req_i = 2'b01;
    w = 0;
    do begin @(negedge clk); w++; end while (bus1.gnt_o == 2'b00 && w < 10);
    bus1.req_i = 2'b00;
    chk("hd1 gnt", bus1.gnt_o, 2'b01);
    c = 1; ng = 0; tog = 0; a1 = '0; prev = sclk1;
    while (bus1.done_o == 2'b00 && c < 200) begin
      @(negedge clk); c++;
      if (sclk1 != prev) tog++;
      if (sclk1 && !prev) begin
        if (ng < 20) a1[ng] = ad1;
        ng++;
      end
      prev = sclk1;
    end
    chk("hd1 done", bus1.done_o, 2'b01);
    chk("hd1 cycles", c, 42);
    chk("hd1 rises", ng, 20);
    chk("hd1 toggles", tog, 40);
    chk("hd1 addr_lane", a1, 20'h0F0F0);
    chk("hd1 rdata", bus1.rdata_o, 16'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
